// File: rtl/alu_pkg.sv
// alu_pkg: operation encodings shared by the ALU and the ALU decoder.
//   ALU_* : 3-bit ALUControl values
//   op_uses_sub() : ops that run the adder in subtract mode
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_SUB  = 3'b001;
    localparam alu_op_t ALU_XOR  = 3'b010;
    localparam alu_op_t ALU_OR   = 3'b011;
    localparam alu_op_t ALU_PACK = 3'b100;
    localparam alu_op_t ALU_SLT  = 3'b101;
    localparam alu_op_t ALU_SLTU = 3'b110;
    localparam alu_op_t ALU_AND  = 3'b111;

    // Both compares are derived from A - B, so they share SUB's adder mode.
    function automatic logic op_uses_sub(input alu_op_t op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: WIDTH-bit adder/subtractor.
//   a, b  : operands
//   sub   : 0 -> a + b, 1 -> a + ~b + 1
//   sum   : result modulo 2^WIDTH
//   cout  : carry out of the MSB
//   ovf   : signed two's-complement overflow of the operation performed
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff        = sub ? ~b : b;
    assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Overflow when both addends share a sign and the sum's sign differs.
    // With sub=1 the second addend is ~b, so this reduces to
    // (a[MSB] != b[MSB]) & (sum[MSB] != a[MSB]).
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// alu: integer ALU for the RV32 single-cycle datapath.
//   clk, reset  : clock (rising edge) and asynchronous active-high reset
//   SrcA, SrcB  : operands
//   ALUControl  : operation select (alu_pkg::ALU_*)
//   ALUResult   : combinational result, same cycle
//   Zero        : combinational, 1 iff ALUResult == 0
//   ResultQ     : ALUResult registered on clk (reset value 0)
//   ZeroQ       : Zero registered on clk (reset value 1)
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] ResultQ,
    output logic             ZeroQ
);

    localparam int HALF = WIDTH / 2;

    if (WIDTH % 2 != 0) begin : g_width_check
        $error("alu: WIDTH must be even for the PACK op");
    end

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             sub;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] result;

    assign sub = op_uses_sub(ALUControl);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (SrcA),
        .b    (SrcB),
        .sub  (sub),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // Signed less-than is N ^ V of A - B, which stays correct when the
    // subtraction overflows (e.g. most-negative vs most-positive).
    assign lt_signed   = sum[WIDTH-1] ^ ovf;
    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    assign lt_unsigned = ~cout;

    always_comb begin
        result = sum;
        case (ALUControl)
            ALU_ADD:  result = sum;
            ALU_SUB:  result = sum;
            ALU_XOR:  result = SrcA ^ SrcB;
            ALU_OR:   result = SrcA | SrcB;
            ALU_PACK: result = {SrcA[WIDTH-1:HALF], SrcB[HALF-1:0]};
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            ALU_AND:  result = SrcA & SrcB;
            default:  result = sum;
        endcase
    end

    assign ALUResult = result;
    assign Zero      = (result == '0);

    // ---- output register stage: copy of result/flag, 1-cycle latency ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ResultQ <= '0;
            ZeroQ   <= 1'b1;
        end else begin
            ResultQ <= result;
            ZeroQ   <= Zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Expected results are queued when a
// vector is driven and popped when the combinational and registered outputs
// are sampled.
module tb_alu;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic [WIDTH-1:0] ResultQ;
    logic             ZeroQ;

    int n_vec = 0;
    int n_bad = 0;

    exp_t comb_q[$];
    exp_t reg_q[$];

    alu #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ResultQ    (ResultQ),
        .ZeroQ      (ZeroQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t e;
        case (op)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = a ^ b;
            3'd3: e.res = a | b;
            3'd4: e.res = {a[WIDTH-1:WIDTH/2], b[WIDTH/2-1:0]};
            3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = a & b;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Drive one vector after the falling edge, check combinational outputs,
    // then the registered copy after the next rising edge.
    task automatic apply(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        @(negedge clk);
        SrcA       = a;
        SrcB       = b;
        ALUControl = op;
        comb_q.push_back(model(op, a, b));
        #1;
        e = comb_q.pop_front();
        chk({tag, ".res"},  ALUResult, e.res);
        chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, e.zero});
        reg_q.push_back(e);
        @(posedge clk);
        #1;
        e = reg_q.pop_front();
        chk({tag, ".resq"},  ResultQ, e.res);
        chk({tag, ".zeroq"}, {31'd0, ZeroQ}, {31'd0, e.zero});
    endtask

    // Fixed expectations straight from the operation table.
    task automatic apply_fixed(input string tag, input logic [2:0] op,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] res, input logic zero);
        @(negedge clk);
        SrcA       = a;
        SrcB       = b;
        ALUControl = op;
        #1;
        chk({tag, ".res"},  ALUResult, res);
        chk({tag, ".zero"}, {31'd0, Zero}, {31'd0, zero});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got 1, expected 0");
        $fatal(1, "tb_alu watchdog");
    end

    logic [WIDTH-1:0] corner [8];

    initial begin
        corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                   32'h7FFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hAAAA_5555};
        reset      = 1'b0;
        SrcA       = 32'd10;
        SrcB       = 32'd5;
        ALUControl = 3'b000;

        // Asynchronous reset: observed before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_async.resq",  ResultQ, 32'd0);
        chk("rst_async.zeroq", {31'd0, ZeroQ}, 32'd1);
        chk("rst_comb.res",    ALUResult, 32'd15);
        @(posedge clk);
        #1;
        chk("rst_held.resq",   ResultQ, 32'd0);
        chk("rst_held.zeroq",  {31'd0, ZeroQ}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.resq",   ResultQ, 32'd15);
        chk("post_rst.zeroq",  {31'd0, ZeroQ}, 32'd0);
        // Reset between edges: registered path clears immediately.
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.resq",    ResultQ, 32'd0);
        chk("rst_mid.zeroq",   {31'd0, ZeroQ}, 32'd1);
        chk("rst_mid.res",     ALUResult, 32'd15);
        chk("rst_mid.zero",    {31'd0, Zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table of required results.
        apply_fixed("add_10_5",   3'b000, 32'd10, 32'd5, 32'd15, 1'b0);
        apply_fixed("sub_10_5",   3'b001, 32'd10, 32'd5, 32'd5,  1'b0);
        apply_fixed("sub_7_7",    3'b001, 32'd7,  32'd7, 32'd0,  1'b1);
        apply_fixed("and_zero",   3'b111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1'b1);
        apply_fixed("or_ones",    3'b011, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
        apply_fixed("slt_5_10",   3'b101, 32'd5, 32'd10, 32'd1, 1'b0);
        apply_fixed("slt_m1_1",   3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        apply_fixed("sltu_m1_1",  3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        apply_fixed("slt_min_max",3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        apply_fixed("slt_max_min",3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        apply_fixed("sltu_1_m1",  3'b110, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
        apply_fixed("pack",       3'b100, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 32'hAAAA_DDDD, 1'b0);
        apply_fixed("xor_same",   3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1);
        apply_fixed("add_wrap",   3'b000, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);

        // Every op over corner operands, then random operands, via the scoreboard.
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < 8; i++) begin
                apply($sformatf("corner_op%0d_%0d", op, i), 3'(op),
                      corner[i], corner[(i + 3) % 8]);
            end
        end
        for (int k = 0; k < 200; k++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            apply($sformatf("rand_%0d", k), 3'($urandom_range(0, 7)), a, b);
        end

        chk("scoreboard_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
